// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields and a sign-extended
// immediate into a 32-bit instruction word through a two-stage valid/ready pipe.
module instr_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [6:0]           i_opcode,
    input  logic [4:0]           i_rd,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [2:0]           i_funct3,
    input  logic [6:0]           i_funct7,
    input  logic [31:0]          i_imm,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [31:0]          o_instr,
    output logic                 o_err,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_U   = 7'b0110111;
    localparam logic [6:0] OP_UPC = 7'b0010111;
    localparam logic [6:0] OP_R   = 7'b0110011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    fields_t              in_fields;
    fields_t              s1_q, s1_d;
    logic                 s1_v_q, s1_v_d;
    logic                 s1_err_q, s1_err_d;
    logic                 s2_v_q, s2_v_d;
    logic                 s2_err_q, s2_err_d;
    logic [31:0]          s2_instr_q, s2_instr_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]          packed_instr;
    logic                 in_err;
    logic                 sext11, sext12, sext20;
    logic                 s1_load, s2_load, out_fire;

    assign in_fields = {i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm};

    assign o_in_ready = ~s1_v_q | ~s2_v_q | i_out_ready;
    assign s1_load    = i_in_valid & o_in_ready & ~i_flush;
    assign s2_load    = s1_v_q & (~s2_v_q | i_out_ready);
    assign out_fire   = s2_v_q & i_out_ready;

    // An immediate fits an N-bit signed field when all bits above it copy the sign
    assign sext11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign sext12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign sext20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        in_err = 1'b1;
        case (i_opcode)
            OP_I, OP_LD, OP_JR, OP_S: in_err = ~sext11;
            OP_B:                     in_err = i_imm[0] | ~sext12;
            OP_J:                     in_err = i_imm[0] | ~sext20;
            OP_U, OP_UPC:             in_err = |i_imm[11:0];
            OP_R:                     in_err = 1'b0;
            default:                  in_err = 1'b1;
        endcase
    end

    // Out-of-range immediates are still packed (truncated); unknown opcodes pack to zero
    always_comb begin
        packed_instr = 32'd0;
        case (s1_q.opcode)
            OP_R:
                packed_instr = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.rd, s1_q.opcode};
            OP_I, OP_LD, OP_JR:
                packed_instr = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3,
                                s1_q.rd, s1_q.opcode};
            OP_S:
                packed_instr = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.imm[4:0], s1_q.opcode};
            OP_B:
                packed_instr = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                                s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
            OP_J:
                packed_instr = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                                s1_q.imm[19:12], s1_q.rd, s1_q.opcode};
            OP_U, OP_UPC:
                packed_instr = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
            default:
                packed_instr = 32'd0;
        endcase
    end

    always_comb begin
        s1_d       = s1_load ? in_fields : s1_q;
        s1_err_d   = s1_load ? in_err : s1_err_q;
        s2_instr_d = s2_load ? packed_instr : s2_instr_q;
        s2_err_d   = s2_load ? s1_err_q : s2_err_q;
        s1_v_d     = s1_load | (s1_v_q & ~s2_load);
        s2_v_d     = s2_load | (s2_v_q & ~i_out_ready);
        err_cnt_d  = err_cnt_q;
        if (i_flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else if (out_fire && s2_err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q       <= '0;
            s1_v_q     <= 1'b0;
            s1_err_q   <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_instr_q <= 32'd0;
            err_cnt_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_v_q     <= s1_v_d;
            s1_err_q   <= s1_err_d;
            s2_v_q     <= s2_v_d;
            s2_err_q   <= s2_err_d;
            s2_instr_q <= s2_instr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign o_out_valid = s2_v_q;
    assign o_instr     = s2_instr_q;
    assign o_err       = s2_err_q;
    assign o_err_cnt   = err_cnt_q;

endmodule
